// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen
//
// Front end for the lamp-pattern FSM. A raw push-button is synchronized and
// debounced, then turned into trigger requests (press, hold-to-repeat, and a
// free-running auto-step). Requests are paced by a small pulse FSM so the
// downstream stage sees each one as a single clean rising edge.
//
// Ports:
//   sysClk   in   system clock, everything is on its rising edge
//   sysRst   in   synchronous active-high reset
//   keyIn    in   raw push-button, asynchronous, active-high
//   autoEn   in   auto-step enable, synchronous
//   trigger  out  paced pulse, PULSE_WIDTH high then at least PULSE_WIDTH low
//   keyLevel out  debounced key level
//   busy     out  pulse FSM not idle, or a request is pending
//   overrun  out  sticky: a request was dropped (cleared only by reset)
module trigger_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8,
    parameter int AUTO_PERIOD     = 10,
    parameter int PULSE_WIDTH     = 2
) (
    input  logic sysClk,
    input  logic sysRst,
    input  logic keyIn,
    input  logic autoEn,
    output logic trigger,
    output logic keyLevel,
    output logic busy,
    output logic overrun
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int AW = $clog2(AUTO_PERIOD + 1);
    localparam int PW = $clog2(PULSE_WIDTH + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic [AW-1:0] AUTO_LAST   = AW'(AUTO_PERIOD - 1);
    localparam logic [PW-1:0] PW_LAST     = PW'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          key_level_q, key_level_d;
    logic          key_prev_q, key_prev_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          repeating_q, repeating_d;
    logic          auto_en_q, auto_en_d;
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    state_t        state_q, state_d;
    logic [PW-1:0] pw_cnt_q, pw_cnt_d;
    logic          pending_q, pending_d;
    logic          trigger_q, trigger_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

    logic press_req, repeat_req, auto_req, req;

    // Synchronizer, debounce and press edge detect.
    always_comb begin
        sync1_d     = keyIn;
        sync2_d     = sync1_q;
        key_prev_d  = key_level_q;
        db_cnt_d    = '0;
        key_level_d = key_level_q;
        if (sync2_q != key_level_q) begin
            // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing
            // samples; any agreeing sample falls through and clears the count.
            if (db_cnt_q == DB_LAST) begin
                key_level_d = ~key_level_q;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
        press_req = key_level_q & ~key_prev_q;
    end

    // Hold-to-repeat: the first interval is REPEAT_DELAY, later ones
    // REPEAT_PERIOD; repeating_q selects which terminal value applies.
    always_comb begin
        hold_cnt_d  = '0;
        repeating_d = 1'b0;
        repeat_req  = 1'b0;
        if (!press_req && key_level_q) begin
            repeating_d = repeating_q;
            if ((!repeating_q && hold_cnt_q == DELAY_LAST) ||
                (repeating_q && hold_cnt_q == PERIOD_LAST)) begin
                repeat_req  = 1'b1;
                repeating_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    // Auto-step. autoEn is taken through one flop, so the counter starts at
    // zero the cycle after autoEn rises and the first request lands
    // AUTO_PERIOD cycles after the rise.
    always_comb begin
        auto_en_d  = autoEn;
        auto_cnt_d = '0;
        auto_req   = 1'b0;
        if (auto_en_q) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_req = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end
    end

    // Coincident requests collapse into one.
    assign req = press_req | repeat_req | auto_req;

    // Pulse FSM: next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        pw_cnt_d  = pw_cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                pw_cnt_d = '0;
                if (req) state_d = ST_HIGH;
            end
            ST_HIGH, ST_LOW: begin
                // One request can wait; a second one while waiting is lost.
                if (req) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (pw_cnt_q == PW_LAST) begin
                    pw_cnt_d = '0;
                    if (state_q == ST_HIGH) begin
                        state_d = ST_LOW;
                    end else if (pending_d) begin
                        // Includes a request arriving in this final LOW cycle.
                        state_d   = ST_HIGH;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pw_cnt_d = pw_cnt_q + PW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pw_cnt_d = '0;
            end
        endcase
        trigger_d = (state_d == ST_HIGH);
        busy_d    = (state_d != ST_IDLE) | pending_d;
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= '0;
            key_level_q <= 1'b0;
            key_prev_q  <= 1'b0;
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
            auto_en_q   <= 1'b0;
            auto_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            pw_cnt_q    <= '0;
            pending_q   <= 1'b0;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            key_level_q <= key_level_d;
            key_prev_q  <= key_prev_d;
            hold_cnt_q  <= hold_cnt_d;
            repeating_q <= repeating_d;
            auto_en_q   <= auto_en_d;
            auto_cnt_q  <= auto_cnt_d;
            state_q     <= state_d;
            pw_cnt_q    <= pw_cnt_d;
            pending_q   <= pending_d;
            trigger_q   <= trigger_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign trigger  = trigger_q;
    assign keyLevel = key_level_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Bench for trigger_pulse_gen. dut_a uses default parameters; dut_b uses
// AUTO_PERIOD=1 so it can be fed a request every cycle. Inputs are driven on
// the falling edge, outputs are observed on the falling edge. cyc counts
// rising edges, so a value seen at a falling edge belongs to edge cyc.
module tb_trigger_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic key_a, auto_a, trig_a, kl_a, busy_a, ovr_a;
    logic key_b, auto_b, trig_b, kl_b, busy_b, ovr_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int rise_a[$];
    int rise_b[$];
    int width_a[$];
    int width_b[$];
    logic [31:0] exp_q[$];
    int run_a = 0;
    int run_b = 0;
    logic trig_a_prev = 1'b0;
    logic trig_b_prev = 1'b0;
    logic kl_seen_a = 1'b0;

    trigger_pulse_gen dut_a (
        .sysClk  (clk),
        .sysRst  (rst),
        .keyIn   (key_a),
        .autoEn  (auto_a),
        .trigger (trig_a),
        .keyLevel(kl_a),
        .busy    (busy_a),
        .overrun (ovr_a)
    );

    trigger_pulse_gen #(.AUTO_PERIOD(1)) dut_b (
        .sysClk  (clk),
        .sysRst  (rst),
        .keyIn   (key_b),
        .autoEn  (auto_b),
        .trigger (trig_b),
        .keyLevel(kl_b),
        .busy    (busy_b),
        .overrun (ovr_b)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records the edge index of each trigger rise and the
    // length of each high run.
    always @(negedge clk) begin
        if (trig_a === 1'b1 && trig_a_prev !== 1'b1) rise_a.push_back(cyc);
        if (trig_b === 1'b1 && trig_b_prev !== 1'b1) rise_b.push_back(cyc);
        if (trig_a === 1'b1) run_a++;
        else if (run_a != 0) begin width_a.push_back(run_a); run_a = 0; end
        if (trig_b === 1'b1) run_b++;
        else if (run_b != 0) begin width_b.push_back(run_b); run_b = 0; end
        if (kl_a === 1'b1) kl_seen_a = 1'b1;
        trig_a_prev = trig_a;
        trig_b_prev = trig_b;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; key_a = 1'b0; auto_a = 1'b0; key_b = 1'b0; auto_b = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (trig_a !== 1'b0) begin miscompares++; $display("FAIL reset_trig_a: got %b want 0", trig_a); end
        vectors++; if (kl_a !== 1'b0) begin miscompares++; $display("FAIL reset_kl_a: got %b want 0", kl_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        vectors++; if (ovr_a !== 1'b0) begin miscompares++; $display("FAIL reset_ovr_a: got %b want 0", ovr_a); end
        vectors++; if (trig_b !== 1'b0) begin miscompares++; $display("FAIL reset_trig_b: got %b want 0", trig_b); end
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        vectors++; if (ovr_b !== 1'b0) begin miscompares++; $display("FAIL reset_ovr_b: got %b want 0", ovr_b); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (busy_a !== 1'b0 || trig_a !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: got busy=%b trig=%b want 0 0", busy_a, trig_a); end
    endtask

    task automatic test_clean_press();
        int b;
        @(negedge clk);
        rise_a.delete(); width_a.delete(); exp_q.delete();
        b = cyc;
        key_a = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (kl_a !== 1'b0) begin miscompares++; $display("FAIL press_kl_early: got %b want 0", kl_a); end
        @(negedge clk);
        vectors++; if (kl_a !== 1'b1) begin miscompares++; $display("FAIL press_kl_rise: got %b want 1", kl_a); end
        repeat (34) @(negedge clk);
        key_a = 1'b0;
        repeat (40) @(negedge clk);
        exp_q.push_back(32'(b + 7));
        exp_q.push_back(32'(b + 27));
        exp_q.push_back(32'(b + 35));
        exp_q.push_back(32'(b + 43));
        vectors++; if (rise_a.size() != exp_q.size()) begin miscompares++; $display("FAIL press_count: got %0d want %0d", rise_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= rise_a.size() || 32'(rise_a[i]) !== exp_q[i]) begin
                miscompares++;
                $display("FAIL press_rise[%0d]: got %0d want %0d", i, (i < rise_a.size()) ? rise_a[i] - b : -1, exp_q[i] - b);
            end
        end
        for (int i = 0; i < width_a.size(); i++) begin
            vectors++; if (width_a[i] != 2) begin miscompares++; $display("FAIL press_width[%0d]: got %0d want 2", i, width_a[i]); end
        end
        vectors++; if (ovr_a !== 1'b0) begin miscompares++; $display("FAIL press_overrun: got %b want 0", ovr_a); end
        vectors++; if (kl_a !== 1'b0) begin miscompares++; $display("FAIL press_kl_release: got %b want 0", kl_a); end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        rise_a.delete();
        kl_seen_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_a = 1'b1;
            repeat (3) @(negedge clk);
            key_a = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        vectors++; if (kl_seen_a !== 1'b0) begin miscompares++; $display("FAIL bounce_kl: got keyLevel high want stays 0"); end
        vectors++; if (rise_a.size() != 0) begin miscompares++; $display("FAIL bounce_pulses: got %0d want 0", rise_a.size()); end
    endtask

    task automatic test_auto();
        int b;
        @(negedge clk);
        rise_a.delete(); width_a.delete(); exp_q.delete();
        b = cyc;
        auto_a = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL auto_busy_before: got %b want 0", busy_a); end
        @(negedge clk);
        vectors++; if (busy_a !== 1'b1 || trig_a !== 1'b1) begin miscompares++; $display("FAIL auto_first: got busy=%b trig=%b want 1 1", busy_a, trig_a); end
        repeat (24) @(negedge clk);
        auto_a = 1'b0;
        repeat (30) @(negedge clk);
        exp_q.push_back(32'(b + 11));
        exp_q.push_back(32'(b + 21));
        exp_q.push_back(32'(b + 31));
        vectors++; if (rise_a.size() != exp_q.size()) begin miscompares++; $display("FAIL auto_count: got %0d want %0d", rise_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= rise_a.size() || 32'(rise_a[i]) !== exp_q[i]) begin
                miscompares++;
                $display("FAIL auto_rise[%0d]: got %0d want %0d", i, (i < rise_a.size()) ? rise_a[i] - b : -1, exp_q[i] - b);
            end
        end
        for (int i = 0; i < width_a.size(); i++) begin
            vectors++; if (width_a[i] != 2) begin miscompares++; $display("FAIL auto_width[%0d]: got %0d want 2", i, width_a[i]); end
        end
    endtask

    task automatic test_coincident();
        int b;
        @(negedge clk);
        rise_a.delete(); exp_q.delete();
        b = cyc;
        auto_a = 1'b1;
        repeat (4) @(negedge clk);
        key_a = 1'b1;
        repeat (8) @(negedge clk);
        auto_a = 1'b0;
        key_a = 1'b0;
        repeat (30) @(negedge clk);
        exp_q.push_back(32'(b + 11));
        vectors++; if (rise_a.size() != 1) begin miscompares++; $display("FAIL coincident_count: got %0d want 1", rise_a.size()); end
        vectors++;
        if (rise_a.size() < 1 || 32'(rise_a[0]) !== exp_q[0]) begin
            miscompares++;
            $display("FAIL coincident_rise: got %0d want %0d", (rise_a.size() > 0) ? rise_a[0] - b : -1, exp_q[0] - b);
        end
        vectors++; if (ovr_a !== 1'b0) begin miscompares++; $display("FAIL coincident_overrun: got %b want 0", ovr_a); end
    endtask

    task automatic test_back_to_back();
        int b;
        @(negedge clk);
        rise_b.delete(); width_b.delete(); exp_q.delete();
        b = cyc;
        auto_b = 1'b1;
        @(negedge clk);
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL burst_busy_idle: got %b want 0", busy_b); end
        @(negedge clk);
        vectors++; if (busy_b !== 1'b1 || trig_b !== 1'b1) begin miscompares++; $display("FAIL burst_first: got busy=%b trig=%b want 1 1", busy_b, trig_b); end
        @(negedge clk);
        auto_b = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if (busy_b !== 1'b1) begin miscompares++; $display("FAIL burst_busy_last_low: got %b want 1", busy_b); end
        @(negedge clk);
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL burst_busy_done: got %b want 0", busy_b); end
        repeat (10) @(negedge clk);
        exp_q.push_back(32'(b + 2));
        exp_q.push_back(32'(b + 6));
        vectors++; if (rise_b.size() != exp_q.size()) begin miscompares++; $display("FAIL burst_count: got %0d want %0d", rise_b.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= rise_b.size() || 32'(rise_b[i]) !== exp_q[i]) begin
                miscompares++;
                $display("FAIL burst_rise[%0d]: got %0d want %0d", i, (i < rise_b.size()) ? rise_b[i] - b : -1, exp_q[i] - b);
            end
        end
        for (int i = 0; i < width_b.size(); i++) begin
            vectors++; if (width_b[i] != 2) begin miscompares++; $display("FAIL burst_width[%0d]: got %0d want 2", i, width_b[i]); end
        end
        vectors++; if (ovr_b !== 1'b1) begin miscompares++; $display("FAIL burst_overrun: got %b want 1", ovr_b); end
        repeat (20) @(negedge clk);
        vectors++; if (ovr_b !== 1'b1) begin miscompares++; $display("FAIL burst_overrun_sticky: got %b want 1", ovr_b); end
    endtask

    task automatic test_reset_mid();
        int b;
        @(negedge clk);
        rise_a.delete(); rise_b.delete(); exp_q.delete();
        b = cyc;
        key_a = 1'b1;
        repeat (10) @(negedge clk);
        auto_b = 1'b1;
        repeat (2) @(negedge clk);
        auto_b = 1'b0;
        @(negedge clk);
        vectors++; if (trig_b !== 1'b1 || busy_b !== 1'b1) begin miscompares++; $display("FAIL midrst_before: got trig=%b busy=%b want 1 1", trig_b, busy_b); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (trig_b !== 1'b0) begin miscompares++; $display("FAIL midrst_trig: got %b want 0", trig_b); end
        vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy_b); end
        vectors++; if (ovr_b !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b want 0", ovr_b); end
        vectors++; if (kl_a !== 1'b0) begin miscompares++; $display("FAIL midrst_kl: got %b want 0", kl_a); end
        repeat (11) @(negedge clk);
        key_a = 1'b0;
        repeat (40) @(negedge clk);
        vectors++; if (rise_b.size() != 1 || (rise_b.size() > 0 && rise_b[0] != b + 12)) begin
            miscompares++;
            $display("FAIL midrst_no_pulse_after: got %0d pulses want 1 at +12", rise_b.size());
        end
        exp_q.push_back(32'(b + 7));
        exp_q.push_back(32'(b + 21));
        vectors++; if (rise_a.size() != exp_q.size()) begin miscompares++; $display("FAIL held_key_count: got %0d want %0d", rise_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (i >= rise_a.size() || 32'(rise_a[i]) !== exp_q[i]) begin
                miscompares++;
                $display("FAIL held_key_rise[%0d]: got %0d want %0d", i, (i < rise_a.size()) ? rise_a[i] - b : -1, exp_q[i] - b);
            end
        end
        vectors++; if (ovr_a !== 1'b0) begin miscompares++; $display("FAIL held_key_overrun: got %b want 0", ovr_a); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto();
        test_coincident();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
